// File: rtl/text_type_ctrl.sv
// Typewriter-style text controller: clears the 16x16 character buffer, then
// types one message character from ROM every FRAMES_PER_CHAR vertical blanks.
module text_type_ctrl #(
    parameter int unsigned FRAMES_PER_CHAR = 4,
    parameter int unsigned MSG_LEN         = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] msg_sel,
    input  logic       vblnk,
    output logic [7:0] msg_addr,
    input  logic [6:0] msg_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [6:0] wr_data,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_CHAR - 1);
    localparam logic [5:0] LAST_IDX   = 6'(MSG_LEN - 1);
    localparam logic [6:0] SPACE      = 7'h20;

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_TICK, FETCH, WRITE, DONE} state_t;

    state_t     state, state_next;
    logic [1:0] msg_sel_q;
    logic [7:0] clr_cnt;
    logic [5:0] idx;
    logic [7:0] frame_cnt;
    logic [6:0] data_q;
    logic       vblnk_q;
    logic       tick;

    assign tick = vblnk & ~vblnk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            msg_sel_q <= '0;
            clr_cnt   <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            data_q    <= '0;
            vblnk_q   <= 1'b0;
        end else begin
            state   <= state_next;
            vblnk_q <= vblnk;
            case (state)
                IDLE: begin
                    if (start) begin
                        msg_sel_q <= msg_sel;
                        clr_cnt   <= '0;
                        idx       <= '0;
                        frame_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt != 8'hFF) clr_cnt <= clr_cnt + 8'd1;
                end
                WAIT_TICK: begin
                    // Ticks are only counted here, so edges during CLEAR/FETCH/WRITE are lost.
                    if (tick) frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 8'd1;
                end
                FETCH: data_q <= msg_data;
                WRITE: begin
                    if (data_q != '0 && idx != LAST_IDX) idx <= idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        done       = 1'b0;
        busy       = (state != IDLE);
        msg_addr   = {msg_sel_q, idx};
        case (state)
            IDLE: if (start) state_next = CLEAR;
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt;
                wr_data = SPACE;
                if (clr_cnt == 8'hFF) state_next = WAIT_TICK;
            end
            WAIT_TICK: if (tick && frame_cnt == LAST_FRAME) state_next = FETCH;
            FETCH: state_next = WRITE;
            WRITE: begin
                if (data_q == '0) begin
                    state_next = DONE;
                end else begin
                    wr_en      = 1'b1;
                    wr_addr    = {2'b00, idx[5:4], idx[3:0]};
                    wr_data    = data_q;
                    state_next = (idx == LAST_IDX) ? DONE : WAIT_TICK;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Reset masks outputs in the same cycle so an abort never leaks a write.
        if (rst) begin
            wr_en    = 1'b0;
            wr_addr  = '0;
            wr_data  = '0;
            done     = 1'b0;
            busy     = 1'b0;
            msg_addr = '0;
        end
    end

endmodule

// File: tb/tb_text_type_ctrl.sv
// Randomized bench for text_type_ctrl: an event-queue model predicts every
// cycle's outputs, plus literal checks on the directed message scenarios.
module tb_text_type_ctrl;

    localparam int FPC  = 4;
    localparam int MLEN = 64;

    logic       clk, rst, start, vblnk;
    logic [1:0] msg_sel;
    logic [7:0] msg_addr, wr_addr;
    logic [6:0] msg_data, wr_data;
    logic       wr_en, busy, done;

    text_type_ctrl #(.FRAMES_PER_CHAR(FPC), .MSG_LEN(MLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .msg_sel(msg_sel), .vblnk(vblnk),
        .msg_addr(msg_addr), .msg_data(msg_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] rom [4][64];
    always @(posedge clk) msg_data <= rom[msg_addr[7:6]][msg_addr[5:0]];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of per-cycle output records; an empty queue while active means waiting for ticks.
    typedef struct {
        bit         we;
        logic [7:0] a;
        logic [6:0] d;
        bit         dn;
        bit         adv;
        bit         fin;
    } rec_t;

    rec_t m_q[$];
    bit   m_active = 0;
    bit   m_prev   = 0;
    int   m_sel    = 0;
    int   m_pos    = 0;
    int   m_ticks  = 0;

    function automatic rec_t mk(bit we, int a, logic [6:0] d, bit dn, bit adv, bit fin);
        rec_t r;
        r.we = we; r.a = 8'(a); r.d = d; r.dn = dn; r.adv = adv; r.fin = fin;
        return r;
    endfunction

    always @(posedge clk) begin
        bit         tk;
        rec_t       r;
        logic [6:0] c;
        tk = vblnk && !m_prev;
        if (rst) begin
            m_active = 0; m_q.delete(); m_sel = 0; m_pos = 0; m_ticks = 0; m_prev = 0;
        end else begin
            m_prev = vblnk;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_sel = int'(msg_sel); m_pos = 0; m_ticks = 0;
                    for (int i = 0; i < 256; i++) m_q.push_back(mk(1, i, 7'h20, 0, 0, 0));
                end
            end else if (m_q.size() != 0) begin
                r = m_q.pop_front();
                if (r.adv) m_pos++;
                if (r.fin) m_active = 0;
            end else if (tk) begin
                m_ticks++;
                if (m_ticks == FPC) begin
                    m_ticks = 0;
                    c = rom[m_sel][m_pos];
                    m_q.push_back(mk(0, 0, 7'h00, 0, 0, 0));
                    if (c == 7'h00) begin
                        m_q.push_back(mk(0, 0, 7'h00, 0, 0, 0));
                        m_q.push_back(mk(0, 0, 7'h00, 1, 0, 1));
                    end else if (m_pos == MLEN - 1) begin
                        m_q.push_back(mk(1, m_pos, c, 0, 0, 0));
                        m_q.push_back(mk(0, 0, 7'h00, 1, 0, 1));
                    end else begin
                        m_q.push_back(mk(1, m_pos, c, 0, 1, 0));
                    end
                end
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [6:0] d;
        int         cyc;
    } wlog_t;

    wlog_t wlog[$];
    int    cyc        = 0;
    int    done_cnt   = 0;
    int    done_cyc   = 0;
    int    clear_seen = 0;
    bit    cmp_en     = 0;

    always @(negedge clk) begin
        rec_t r;
        logic [7:0] e_ma;
        cyc++;
        if (cmp_en) begin
            r = mk(0, 0, 7'h00, 0, 0, 0);
            e_ma = 8'(m_sel * 64 + m_pos);
            if (m_active && m_q.size() != 0) r = m_q[0];
            if (rst) e_ma = 8'h00;
            chk("busy", busy, (m_active && !rst) ? 1 : 0);
            chk("wr_en", wr_en, (r.we && !rst) ? 1 : 0);
            chk("wr_addr", wr_addr, rst ? 0 : r.a);
            chk("wr_data", wr_data, rst ? 0 : r.d);
            chk("done", done, (r.dn && !rst) ? 1 : 0);
            chk("msg_addr", msg_addr, e_ma);
        end
        if (wr_en && wr_data == 7'h20) begin
            chk("clear_addr", wr_addr, clear_seen);
            clear_seen++;
        end else if (wr_en) begin
            wlog.push_back('{a: wr_addr, d: wr_data, cyc: cyc});
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    bit vhold = 0;
    initial begin
        int vcnt = 0;
        int vper = 8;
        vblnk = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (vhold) vblnk = 1'b1;
            else begin
                vcnt++;
                if (vcnt >= vper) begin
                    vcnt = 0;
                    vper = $urandom_range(5, 12);
                end
                vblnk = (vcnt < 2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [1:0] sel);
        wlog.delete();
        clear_seen = 0;
        msg_sel = sel;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        chk(nm, (done_cnt != d0) ? 1 : 0, 1);
    endtask

    initial begin
        int d0, n0, n, k;
        rst = 1'b1; start = 1'b0; msg_sel = 2'd0;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 64; i++) rom[s][i] = 7'h00;
        rom[2][0] = 7'h48;
        rom[2][1] = 7'h49;
        for (int i = 0; i < 64; i++) rom[1][i] = 7'(8'h21 + i);
        for (int i = 0; i < 7; i++) rom[0][i] = 7'(8'h41 + i);
        k = $urandom_range(10, 63);
        for (int i = 0; i < k; i++) rom[3][i] = 7'($urandom_range(8'h21, 8'h7E));

        step();
        step();
        cmp_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_msg_addr", msg_addr, 0);
        rst = 1'b0;
        step();

        // "HI" message
        do_start(2'd2);
        chk("a_busy", busy, 1);
        chk("a_msg_addr", msg_addr, 8'h80);
        chk("a_first_clear", wr_addr, 8'h00);
        wait_done(2000, "a_done_timeout");
        chk("a_idle", busy, 0);
        chk("a_clears", clear_seen, 256);
        chk("a_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("a_w0_addr", wlog[0].a, 8'h00);
            chk("a_w0_data", wlog[0].d, 7'h48);
            chk("a_w1_addr", wlog[1].a, 8'h01);
            chk("a_w1_data", wlog[1].d, 7'h49);
        end

        // 64 characters, no terminator
        step();
        do_start(2'd1);
        wait_done(6000, "b_done_timeout");
        chk("b_nwrites", wlog.size(), 64);
        if (wlog.size() == 64) begin
            chk("b_w16_addr", wlog[16].a, 8'h10);
            chk("b_w16_data", wlog[16].d, 7'h31);
            chk("b_last_addr", wlog[63].a, 8'h3F);
            chk("b_last_data", wlog[63].d, 7'h60);
            chk("b_done_lag", done_cyc - wlog[63].cyc, 1);
        end

        // ignored starts and a long vblnk pulse
        step();
        do_start(2'd2);
        repeat (10) step();
        msg_sel = 2'd3; start = 1'b1; step(); start = 1'b0;
        repeat (260) step();
        msg_sel = 2'd3; start = 1'b1; step(); start = 1'b0;
        chk("c_sel_kept", msg_addr[7:6], 2);
        vhold = 1;
        repeat (100) step();
        vhold = 0;
        wait_done(2000, "c_done_timeout");
        chk("c_nwrites", wlog.size(), 2);

        // reset after three characters
        step();
        do_start(2'd0);
        n = 0;
        while (wlog.size() < 3 && n < 3000) begin
            step();
            n++;
        end
        chk("d_three_timeout", (wlog.size() >= 3) ? 1 : 0, 1);
        rst = 1'b1;
        step();
        chk("d_rst_busy", busy, 0);
        chk("d_rst_wr_en", wr_en, 0);
        rst = 1'b0;
        d0 = done_cnt;
        n0 = wlog.size();
        repeat (150) step();
        chk("d_no_done", done_cnt, d0);
        chk("d_no_write", wlog.size(), n0);
        do_start(2'd0);
        chk("d_restart_we", wr_en, 1);
        chk("d_restart_addr", wr_addr, 8'h00);
        wait_done(2000, "d_done_timeout");

        // random messages, stray starts, one mid-run reset
        for (int it = 0; it < 6; it++) begin
            step();
            do_start(2'($urandom_range(0, 3)));
            k = (it == 2) ? $urandom_range(50, 600) : 8000;
            d0 = done_cnt;
            n = 0;
            while (done_cnt == d0 && n < k) begin
                msg_sel = 2'($urandom_range(0, 3));
                start = busy && ($urandom_range(0, 49) == 0);
                step();
                n++;
            end
            start = 1'b0;
            if (it == 2) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("r_rst_busy", busy, 0);
            end else begin
                chk("r_done_timeout", (done_cnt != d0) ? 1 : 0, 1);
            end
        end
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
